// File: rtl/rr_mux4_stream.sv
// rtl/rr_mux4_stream.sv - 4:1 round-robin packet stream merger with source tag
// Grants are held per packet; priority rotates past the source whose packet just ended.
module rr_mux4_stream #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [3:0]          in_last,
  output logic [3:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic [1:0]          out_sel,
  input  logic                out_ready
);

  typedef enum logic {IDLE, PASS} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [1:0]        out_sel_q, out_sel_d;

  logic [1:0]        pick;
  logic              pick_found;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] grant_data;
  logic              grant_last;

  // First requester at or after rr_ptr, wrapping modulo 4.
  always_comb begin
    pick       = rr_ptr_q;
    pick_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!pick_found && in_valid[rr_ptr_q + 2'(i)]) begin
        pick       = rr_ptr_q + 2'(i);
        pick_found = 1'b1;
      end
    end
  end

  assign grant_data = in_data[grant_q*DATA_W +: DATA_W];
  assign grant_last = in_last[grant_q];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    in_ready    = 4'b0000;
    can_accept  = !out_valid_q || out_ready;
    accept      = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick;
          state_d = PASS;
        end
      end
      PASS: begin
        in_ready[grant_q] = can_accept;
        accept            = can_accept && in_valid[grant_q];
        // A new accept overrides the drain above, so a same-cycle drain+load keeps out_valid high.
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = grant_data;
          out_last_d  = grant_last;
          out_sel_d   = grant_q;
          if (grant_last) begin
            rr_ptr_d = grant_q + 2'd1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 2'd0;
      rr_ptr_q    <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux4_stream.sv
// tb/tb_rr_mux4_stream.sv - bench for rr_mux4_stream
// Sources and a packet-level arbitration/scoreboard model live here; outputs sampled on the falling edge.
module tb_rr_mux4_stream;
  localparam int DATA_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          in_valid;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_last;
  logic [3:0]          in_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic [1:0]          out_sel;
  logic                out_ready;

  always #5 clk = ~clk;

  rr_mux4_stream #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [8:0]  smem [4][256];
  int          swr [4];
  int          srd [4];
  logic [3:0]  en;
  logic [3:0]  held;
  int          rnd_valid;
  int          rnd_ready;
  logic [10:0] exp_q [$];
  logic [10:0] log_q [$];
  int          log_t [$];
  logic        m_idle;
  logic [1:0]  m_ptr;
  logic [1:0]  m_src;
  logic [10:0] snap;
  int          c0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      if (swr[k] == srd[k]) held[k] = 1'b0;
      else if (!held[k] && en[k] && ($urandom_range(99) < rnd_valid)) held[k] = 1'b1;
      in_valid[k] = held[k];
      {in_last[k], in_data[k*DATA_W +: DATA_W]} = smem[k][srd[k] % 256];
    end
    out_ready = ($urandom_range(99) < rnd_ready);
  endtask

  task automatic push_pkt(input int k, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      smem[k][swr[k] % 256] = {(i == n - 1), base + i[7:0]};
      swr[k]++;
    end
  endtask

  task automatic cycle();
    logic [3:0] exp_rdy;
    logic       was_rst;
    logic       found;
    @(negedge clk);
    was_rst = rst;
    if (!rst) begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("out_beat", {out_sel, out_last, out_data}, exp_q[0]);
      chk("in_ready_onehot0", $onehot0(in_ready), 1);
      exp_rdy = 4'b0000;
      if (!m_idle && (exp_q.size() == 0 || out_ready)) exp_rdy[m_src] = 1'b1;
      chk("in_ready", in_ready, exp_rdy);
      if (out_valid && out_ready) begin
        log_q.push_back({out_sel, out_last, out_data});
        log_t.push_back(cyc);
      end
      if (exp_q.size() != 0 && out_ready) exp_q.delete(0);
      if (m_idle) begin
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (!found && in_valid[(int'(m_ptr) + i) % 4]) begin
            m_src = 2'((int'(m_ptr) + i) % 4);
            found = 1'b1;
          end
        end
        if (found) m_idle = 1'b0;
      end else if (in_valid[m_src] && exp_rdy[m_src]) begin
        exp_q.push_back({m_src, smem[m_src][srd[m_src] % 256]});
        if (smem[m_src][srd[m_src] % 256][8]) begin
          m_ptr  = m_src + 2'd1;
          m_idle = 1'b1;
        end
        srd[m_src]++;
        held[m_src] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) begin
      for (int k = 0; k < 4; k++) srd[k] = swr[k];
      held = 4'b0000;
      exp_q.delete();
      m_idle = 1'b1;
      m_ptr  = 2'd0;
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_log();
    log_q.delete();
    log_t.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
    en = 4'hF; held = '0; rnd_valid = 100; rnd_ready = 100;
    m_idle = 1'b1; m_ptr = '0; m_src = '0;
    for (int k = 0; k < 4; k++) begin swr[k] = 0; srd[k] = 0; end
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_in_ready", in_ready, 0);

    // 1: three-beat packet from source 2
    clear_log();
    push_pkt(2, 3, 8'hA0);
    drive();
    c0 = cyc;
    run(8);
    chk("t1_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t1_latency", log_t[0], c0 + 2);
      for (int i = 0; i < 3; i++) begin
        chk("t1_beat", log_q[i], {2'd2, (i == 2), 8'hA0 + i[7:0]});
        if (i > 0) chk("t1_spacing", log_t[i] - log_t[i-1], 1);
      end
    end

    // 2: single-beat packets from all sources after reset
    do_reset();
    clear_log();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) push_pkt(k, 1, 8'(8'h10 + 16 * r + k));
    drive();
    run(20);
    chk("t2_count", log_q.size(), 8);
    if (log_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t2_sel", log_q[i][10:9], i % 4);
        if (i > 0) chk("t2_bubble", log_t[i] - log_t[i-1], 2);
      end
    end

    // 3: source 1 stalls mid-packet while 0 and 3 wait
    clear_log();
    push_pkt(1, 4, 8'h30);
    drive();
    run(3);
    en[1] = 1'b0;
    push_pkt(0, 2, 8'h40);
    push_pkt(3, 2, 8'h50);
    run(6);
    chk("t3_locked", log_q.size() <= 3, 1);
    en[1] = 1'b1;
    run(15);
    chk("t3_count", log_q.size(), 8);
    if (log_q.size() == 8) begin
      chk("t3_b0", log_q[0], {2'd1, 1'b0, 8'h30});
      chk("t3_b3", log_q[3], {2'd1, 1'b1, 8'h33});
      chk("t3_b4", log_q[4], {2'd3, 1'b0, 8'h50});
      chk("t3_b5", log_q[5], {2'd3, 1'b1, 8'h51});
      chk("t3_b6", log_q[6], {2'd0, 1'b0, 8'h40});
      chk("t3_b7", log_q[7], {2'd0, 1'b1, 8'h41});
    end

    // 4: sink backpressure for four cycles
    clear_log();
    push_pkt(1, 4, 8'h60);
    drive();
    run(3);
    rnd_ready = 0;
    out_ready = 1'b0;
    snap = {out_sel, out_last, out_data};
    chk("t4_held_valid", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t4_stable", {out_sel, out_last, out_data}, snap);
      chk("t4_valid", out_valid, 1);
      chk("t4_in_ready", in_ready, 0);
    end
    rnd_ready = 100;
    out_ready = 1'b1;
    run(10);
    chk("t4_count", log_q.size(), 4);
    if (log_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("t4_beat", log_q[i], {2'd1, (i == 3), 8'h60 + i[7:0]});

    // 5: reset in the middle of a packet
    push_pkt(2, 4, 8'h70);
    drive();
    run(3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_out_data", out_data, 0);
    clear_log();
    push_pkt(3, 1, 8'h90);
    push_pkt(0, 1, 8'h80);
    drive();
    run(8);
    chk("t5_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t5_first", log_q[0], {2'd0, 1'b1, 8'h80});
      chk("t5_second", log_q[1], {2'd3, 1'b1, 8'h90});
    end

    // 6: random traffic against the scoreboard, then drain
    do_reset();
    rnd_valid = 40;
    rnd_ready = 60;
    for (int t = 0; t < 600; t++) begin
      for (int k = 0; k < 4; k++)
        if (swr[k] - srd[k] < 6 && $urandom_range(7) == 0)
          push_pkt(k, $urandom_range(4, 1), 8'($urandom_range(255)));
      cycle();
    end
    rnd_valid = 100;
    rnd_ready = 100;
    run(150);
    for (int k = 0; k < 4; k++) chk("t6_drained", swr[k] - srd[k], 0);
    chk("t6_out_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
